inst_fetch_unit: RTL and testbench

- Parametrised instruction fetch front end for the CPU.
- Generates the PC and issues requests to a fixed-latency instruction memory (ROM).
- Buffers the returned instructions, each with its PC, in a small prefetch FIFO.
- Delivers them downstream over a valid/ready handshake. Supports branch redirect with flush of buffered and in-flight fetches.

---
 rtl/inst_fetch_unit.sv | 87 ++++++++
 tb/tb_inst_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch front end with prefetch FIFO and branch redirect
// Issues fixed-latency ROM requests and buffers {inst, pc} pairs for a valid/ready consumer.
module inst_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h00400000,
  parameter int               DEPTH    = 4
) (
  input  logic             clk_cpu,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_inst,
  output logic [WIDTH-1:0] out_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] inflight_pc;
  logic             inflight;
  logic [CW-1:0]    count;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [WIDTH-1:0] inst_q [DEPTH];
  logic [WIDTH-1:0] pc_q   [DEPTH];

  logic             pop;
  logic             push;
  logic [CW:0]      occupancy;

  assign out_valid = (count != '0);
  assign out_inst  = inst_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push      = inflight & ~redirect;

  // Credit check counts the in-flight slot so a response never lands in a full FIFO.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign imem_req  = ~reset & ~redirect & (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect) begin
      // Flush buffered and in-flight work; a same-cycle pop is discarded too.
      fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00};
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (imem_req) begin
        fetch_pc    <= fetch_pc + WIDTH'(4);
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
      end else begin
        inflight    <= 1'b0;
      end
      if (push) begin
        inst_q[wr_ptr] <= imem_rdata;
        pc_q[wr_ptr]   <= inflight_pc;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
// Main instance uses the default RESET_PC; a second instance covers address wrap.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] rom_addr = 32'h0;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic [31:0] w_rom_addr = 32'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (((a - 32'h00400000) >> 2) + 32'd1) * 32'h11;
  endfunction

  always @(posedge clk) if (imem_req) rom_addr <= imem_addr;
  assign imem_rdata = rom_word(rom_addr);
  always @(posedge clk) if (w_req) w_rom_addr <= w_addr;
  assign w_rdata = ~w_rom_addr;

  inst_fetch_unit dut (
    .clk_cpu(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
  );

  inst_fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFFFFF8), .DEPTH(4)) dut_wrap (
    .clk_cpu(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .out_valid(w_valid), .out_ready(w_ready), .out_inst(w_inst), .out_pc(w_pc)
  );

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got=%0b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h00400000) begin failures++; $display("FAIL reset_imem_addr got=%h exp=00400000", imem_addr); end
    checks++; if (out_inst !== 32'h0 || out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h/%h exp=0/0", out_inst, out_pc); end
  endtask

  task automatic test_stream();
    apply_reset();
    out_ready = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h00400000) begin failures++; $display("FAIL stream_first_req got=%0b/%h exp=1/00400000", imem_req, imem_addr); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_latency got=%0b exp=0", out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_inst !== 32'h11 || out_pc !== 32'h00400000) begin failures++; $display("FAIL stream_first got=%0b/%h/%h exp=1/00000011/00400000", out_valid, out_inst, out_pc); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h00400000 + 32'(4*k) || out_inst !== 32'(17*(k+1))) begin failures++; $display("FAIL stream_seq%0d got=%0b/%h/%h exp=1/%h/%h", k, out_valid, out_inst, out_pc, 32'(17*(k+1)), 32'h00400000 + 32'(4*k)); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_stalled got=%0b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h00400010) begin failures++; $display("FAIL bp_four_fetched got=%h exp=00400010", imem_addr); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h00400000) begin failures++; $display("FAIL bp_head got=%0b/%h exp=1/00400000", out_valid, out_pc); end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h00400000 + 32'(4*k) || out_inst !== 32'(17*(k+1))) begin failures++; $display("FAIL bp_drain%0d got=%0b/%h/%h exp=1/%h/%h", k, out_valid, out_inst, out_pc, 32'(17*(k+1)), 32'h00400000 + 32'(4*k)); end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    out_ready = 1'b0;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h00400000) begin failures++; $display("FAIL redir_pre got=%0b/%h exp=1/00400000", out_valid, out_pc); end
    redirect = 1'b1;
    redirect_pc = 32'h00400100;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_no_req got=%0b exp=0", imem_req); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h00400100 || imem_req !== 1'b1) begin failures++; $display("FAIL redir_flush got=%0b/%h/%0b exp=0/00400100/1", out_valid, imem_addr, imem_req); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_stale got=%0b exp=0", out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h00400100 || out_inst !== 32'h451) begin failures++; $display("FAIL redir_first got=%0b/%h/%h exp=1/00000451/00400100", out_valid, out_inst, out_pc); end
    out_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h00400104 || out_inst !== 32'h462) begin failures++; $display("FAIL redir_second got=%0b/%h/%h exp=1/00000462/00400104", out_valid, out_inst, out_pc); end
  endtask

  task automatic test_redirect_pop();
    apply_reset();
    out_ready = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h00400106;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rpop_valid_before got=%0b exp=1", out_valid); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h00400104) begin failures++; $display("FAIL rpop_align got=%0b/%h exp=0/00400104", out_valid, imem_addr); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h00400104 || out_inst !== 32'h462) begin failures++; $display("FAIL rpop_first got=%0b/%h/%h exp=1/00000462/00400104", out_valid, out_inst, out_pc); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0 || out_pc !== 32'h0) begin failures++; $display("FAIL areset_immediate got=%0b/%0b/%h exp=0/0/0", out_valid, imem_req, out_pc); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h00400000 || out_valid !== 1'b0) begin failures++; $display("FAIL areset_restart got=%h/%0b exp=00400000/0", imem_addr, out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_no_leftover got=%0b exp=0", out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h00400000 || out_inst !== 32'h11) begin failures++; $display("FAIL areset_first got=%0b/%h/%h exp=1/00000011/00400000", out_valid, out_inst, out_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    apply_reset();
    reset = 1'b0;
    #1;
    checks++; if (w_addr !== 32'hFFFFFFF8 || w_valid !== 1'b0) begin failures++; $display("FAIL wrap_start got=%h/%0b exp=fffffff8/0", w_addr, w_valid); end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      exp_pc = 32'hFFFFFFF8 + 32'(4*k);
      checks++; if (w_valid !== 1'b1 || w_pc !== exp_pc || w_inst !== ~exp_pc) begin failures++; $display("FAIL wrap_seq%0d got=%0b/%h/%h exp=1/%h/%h", k, w_valid, w_inst, w_pc, ~exp_pc, exp_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
